// File: rtl/gs_round_sched_pkg.sv
// Shared definitions for the Gaussian-elimination round scheduler:
// FSM state encoding and sizing helpers.
package gs_round_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ELIM_GO,
    ST_ELIM_WAIT,
    ST_UNLOAD,
    ST_FIN
  } state_t;

  // One slot per in-flight read plus one so a stalled consumer never drops data.
  function automatic int fifo_depth(input int read_delay);
    return read_delay + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gs_round_sched_if.sv
// Row-load and result streams of the round scheduler, valid/ready handshaked.
// master drives load rows and consumes results; slave is the scheduler.
interface gs_round_sched_if #(
  parameter int L = 4
) ();
  logic         load_valid;
  logic         load_ready;
  logic [L-1:0] load_data;
  logic         out_valid;
  logic         out_ready;
  logic [L-1:0] out_data;

  modport master (
    output load_valid, load_data, out_ready,
    input  load_ready, out_valid, out_data
  );

  modport slave (
    input  load_valid, load_data, out_ready,
    output load_ready, out_valid, out_data
  );
endinterface

// File: rtl/gs_round_sched_rd_skid_fifo.sv
// Small circular FIFO catching unload read data; zero-latency read (pop_data
// shows the head). Pushes when full and pops when empty are dropped.
module rd_skid_fifo
  import gs_round_sched_pkg::*;
#(
  parameter  int DEPTH = 3,
  parameter  int W     = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = idx_width(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gs_round_sched.sv
// Job sequencer: loads rows, hands the memory to the elimination controller per round,
// then unloads D result rows through a skid FIFO so out_ready stalls never lose data.
module gs_round_sched
  import gs_round_sched_pkg::*;
#(
  parameter  int K          = 6,
  parameter  int K1         = 5,
  parameter  int L          = 4,
  parameter  int D          = 2,
  parameter  int NUM_ROUNDS = 2,
  parameter  int READ_DELAY = 2,
  localparam int AW         = $clog2(K)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  output logic          busy,
  output logic          done,
  gs_round_sched_if.slave strm,
  output logic          ge_start,
  output logic          ge_mat_sel,
  output logic          ge_is_last,
  input  logic          ge_done,
  input  logic [AW-1:0] ge_addra,
  input  logic [AW-1:0] ge_addrb,
  input  logic          ge_rwa,
  input  logic          ge_rwb,
  input  logic [L-1:0]  ge_doutb,
  output logic [AW-1:0] mem_addra,
  output logic [AW-1:0] mem_addrb,
  output logic          mem_rwa,
  output logic          mem_rwb,
  output logic [L-1:0]  mem_dinb,
  input  logic [L-1:0]  mem_douta
);

  localparam int RW    = $clog2(K + 1);
  localparam int NW    = $clog2(NUM_ROUNDS + 1);
  localparam int UW    = $clog2(D + 1);
  localparam int DEPTH = fifo_depth(READ_DELAY);
  localparam int CW    = $clog2(DEPTH + 1);

  state_t                state;
  logic [RW-1:0]         row_cnt;
  logic [NW-1:0]         round;
  logic [UW-1:0]         issue_cnt;
  logic [UW-1:0]         pop_cnt;
  logic                  load_ready_q;
  logic [READ_DELAY-1:0] rd_pipe;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [L-1:0]          fifo_dout;

  logic          load_fire;
  logic          pop;
  logic          rd_issue;
  logic          last_round;
  logic [RW-1:0] rows_m1;

  assign strm.load_ready = load_ready_q;
  assign strm.out_valid  = !fifo_empty;
  assign strm.out_data   = fifo_dout;

  assign load_fire  = strm.load_valid & load_ready_q;
  assign pop        = strm.out_valid & strm.out_ready;
  assign last_round = (round == NW'(NUM_ROUNDS - 1));
  assign rows_m1    = (round == '0) ? RW'(K - 1) : RW'(K1 - 1);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_DELAY; i++) inflight = inflight + CW'(rd_pipe[i]);
  end

  // Count reads still in the memory pipe as already occupying a FIFO slot.
  assign rd_issue = (state == ST_UNLOAD) && (issue_cnt < UW'(D)) &&
                    (({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_issue;
      for (int i = 1; i < READ_DELAY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  rd_skid_fifo #(
    .DEPTH (DEPTH),
    .W     (L)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (rd_pipe[READ_DELAY-1]),
    .push_data (mem_douta),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_comb begin
    mem_addra = '0;
    mem_addrb = '0;
    mem_rwa   = 1'b0;
    mem_rwb   = 1'b0;
    mem_dinb  = '0;
    case (state)
      ST_LOAD: begin
        mem_addrb = row_cnt[AW-1:0];
        mem_rwb   = load_fire;
        mem_dinb  = strm.load_data;
      end
      ST_ELIM_WAIT: begin
        mem_addra = ge_addra;
        mem_addrb = ge_addrb;
        mem_rwa   = ge_rwa;
        mem_rwb   = ge_rwb;
        mem_dinb  = ge_doutb;
      end
      ST_UNLOAD: begin
        if (rd_issue) mem_addra = AW'(issue_cnt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= ST_IDLE;
      row_cnt      <= '0;
      round        <= '0;
      issue_cnt    <= '0;
      pop_cnt      <= '0;
      load_ready_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ge_start     <= 1'b0;
      ge_mat_sel   <= 1'b0;
      ge_is_last   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_LOAD;
            busy         <= 1'b1;
            load_ready_q <= 1'b1;
            row_cnt      <= '0;
            round        <= '0;
          end
        end
        ST_LOAD: begin
          if (load_fire) begin
            row_cnt <= row_cnt + RW'(1);
            if (row_cnt == rows_m1) begin
              load_ready_q <= 1'b0;
              state        <= ST_ELIM_GO;
              ge_start     <= 1'b1;
              ge_mat_sel   <= (round != '0);
              ge_is_last   <= last_round;
            end
          end
        end
        ST_ELIM_GO: begin
          ge_start <= 1'b0;
          state    <= ST_ELIM_WAIT;
        end
        ST_ELIM_WAIT: begin
          if (ge_done) begin
            ge_mat_sel <= 1'b0;
            ge_is_last <= 1'b0;
            if (!last_round) begin
              round        <= round + NW'(1);
              row_cnt      <= '0;
              load_ready_q <= 1'b1;
              state        <= ST_LOAD;
            end else begin
              issue_cnt <= '0;
              pop_cnt   <= '0;
              state     <= ST_UNLOAD;
            end
          end
        end
        ST_UNLOAD: begin
          if (rd_issue) issue_cnt <= issue_cnt + UW'(1);
          if (pop) begin
            pop_cnt <= pop_cnt + UW'(1);
            if (pop_cnt == UW'(D - 1)) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_round_sched.sv
// Directed bench for gs_round_sched: two-round job with a stubbed elimination
// controller and memory model, unload backpressure, ignored strays, mid-load reset.
module tb_gs_round_sched;

  localparam int K = 6, K1 = 5, L = 4, D = 2, NR = 2, RD = 2, AW = 3;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic          ge_start, ge_mat_sel, ge_is_last;
  logic          ge_done = 1'b0;
  logic [AW-1:0] ge_addra = 3'd2;
  logic [AW-1:0] ge_addrb = 3'd5;
  logic          ge_rwa = 1'b1;
  logic          ge_rwb = 1'b0;
  logic [L-1:0]  ge_doutb = 4'hA;
  logic [AW-1:0] mem_addra, mem_addrb;
  logic          mem_rwa, mem_rwb;
  logic [L-1:0]  mem_dinb, mem_douta;

  logic [L-1:0] r0 [K]  = '{4'h3, 4'h9, 4'h5, 4'hC, 4'h6, 4'hE};
  logic [L-1:0] r1 [K1] = '{4'h7, 4'h1, 4'hB, 4'h2, 4'hD};

  gs_round_sched_if #(.L(L)) sif ();

  gs_round_sched #(
    .K(K), .K1(K1), .L(L), .D(D), .NUM_ROUNDS(NR), .READ_DELAY(RD)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .strm       (sif),
    .ge_start   (ge_start),
    .ge_mat_sel (ge_mat_sel),
    .ge_is_last (ge_is_last),
    .ge_done    (ge_done),
    .ge_addra   (ge_addra),
    .ge_addrb   (ge_addrb),
    .ge_rwa     (ge_rwa),
    .ge_rwb     (ge_rwb),
    .ge_doutb   (ge_doutb),
    .mem_addra  (mem_addra),
    .mem_addrb  (mem_addrb),
    .mem_rwa    (mem_rwa),
    .mem_rwb    (mem_rwb),
    .mem_dinb   (mem_dinb),
    .mem_douta  (mem_douta)
  );

  always #5 clk = ~clk;

  // Memory: port-b writes, port-a reads returned RD cycles after the address.
  logic [L-1:0] mem   [K];
  logic [L-1:0] rpipe [RD];
  always @(posedge clk) begin
    if (mem_rwb) mem[mem_addrb] <= mem_dinb;
    rpipe[0] <= mem[mem_addra];
    for (int i = 1; i < RD; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_douta = rpipe[RD-1];

  int total = 0;
  int bad = 0;
  int ge_cnt = 0;
  int done_cnt = 0;
  int pops = 0;
  logic [L-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output scoreboard and event counters.
  always @(negedge clk) begin
    if (rst_b) begin
      if (ge_start) ge_cnt++;
      if (done) done_cnt++;
    end
    if (sif.out_valid && sif.out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_extra: got %0h with nothing expected", sif.out_data);
      end else begin
        chk("out_data", 32'(sif.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rows(input int n, input int rnd, input bit gaps, input bit spur);
    logic [L-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = (rnd == 0) ? r0[i] : r1[i];
      sif.load_valid = 1'b1;
      sif.load_data  = d;
      @(negedge clk);
      chk("load_ready", 32'(sif.load_ready), 1);
      chk("wr_en", 32'(mem_rwb), 1);
      chk("wr_addr", 32'(mem_addrb), i);
      chk("wr_data", 32'(mem_dinb), 32'(d));
      cyc();
      sif.load_valid = 1'b0;
      if (gaps && i < n - 1) begin
        if (spur && i == 2) ge_done = 1'b1;
        @(negedge clk);
        chk("wr_gap", 32'(mem_rwb), 0);
        chk("no_mirror_load", 32'(mem_rwa), 0);
        cyc();
        ge_done = 1'b0;
      end
    end
  endtask

  task automatic elim(input bit sel, input bit last, input bit poke_start);
    @(negedge clk);
    chk("ge_start", 32'(ge_start), 1);
    chk("ge_mat_sel", 32'(ge_mat_sel), 32'(sel));
    chk("ge_is_last", 32'(ge_is_last), 32'(last));
    chk("load_ready_fall", 32'(sif.load_ready), 0);
    chk("no_mirror_go", 32'(mem_rwa), 0);
    cyc();
    if (poke_start) start = 1'b1;
    @(negedge clk);
    chk("ge_start_pulse", 32'(ge_start), 0);
    chk("mat_sel_held", 32'(ge_mat_sel), 32'(sel));
    chk("is_last_held", 32'(ge_is_last), 32'(last));
    chk("mirror_addra", 32'(mem_addra), 2);
    chk("mirror_addrb", 32'(mem_addrb), 5);
    chk("mirror_rwa", 32'(mem_rwa), 1);
    chk("mirror_rwb", 32'(mem_rwb), 0);
    chk("mirror_dinb", 32'(mem_dinb), 32'hA);
    cyc();
    start = 1'b0;
    repeat (8) cyc();
    ge_done = 1'b1;
    cyc();
    ge_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    sif.load_valid = 1'b0;
    sif.load_data  = '0;
    sif.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_load_ready", 32'(sif.load_ready), 0);
    chk("rst_out_valid", 32'(sif.out_valid), 0);
    chk("rst_out_data", 32'(sif.out_data), 0);
    chk("rst_ge_start", 32'(ge_start), 0);
    chk("rst_mem_rwa", 32'(mem_rwa), 0);
    chk("rst_mem_rwb", 32'(mem_rwb), 0);
    chk("rst_mem_addra", 32'(mem_addra), 0);
    chk("rst_mem_addrb", 32'(mem_addrb), 0);
    cyc();
    rst_b = 1'b1;
    cyc();

    // Job 1: round 0 with gapped loads and a stray ge_done, then round 1.
    start = 1'b1;
    cyc();
    start = 1'b0;
    load_rows(K, 0, 1'b1, 1'b1);
    elim(1'b0, 1'b0, 1'b1);
    exp_q.push_back(r1[0]);
    exp_q.push_back(r1[1]);
    load_rows(K1, 1, 1'b0, 1'b0);
    elim(1'b1, 1'b1, 1'b0);

    @(negedge clk);
    chk("unload_addr0", 32'(mem_addra), 0);
    chk("unload_rwa", 32'(mem_rwa), 0);
    chk("unload_busy", 32'(busy), 1);
    @(negedge clk);
    chk("unload_addr1", 32'(mem_addra), 1);
    @(negedge clk);
    chk("unload_addr_idle", 32'(mem_addra), 0);
    for (int c = 0; c < 20 && !sif.out_valid; c++) @(negedge clk);
    chk("out_valid_rise", 32'(sif.out_valid), 1);
    repeat (8) begin
      @(negedge clk);
      chk("stall_valid", 32'(sif.out_valid), 1);
      chk("stall_data", 32'(sif.out_data), 32'(r1[0]));
    end
    cyc();
    sif.out_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) @(negedge clk);
    chk("done_pulse", 32'(done), 1);
    chk("busy_in_fin", 32'(busy), 1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("pop_count", pops, 2);
    chk("exp_drained", exp_q.size(), 0);
    chk("ge_start_count", ge_cnt, 2);

    // Job 2: reset while the fourth row is being offered.
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    load_rows(3, 0, 1'b0, 1'b0);
    sif.load_valid = 1'b1;
    sif.load_data  = r0[3];
    #1 rst_b = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_load_ready", 32'(sif.load_ready), 0);
    chk("arst_mem_rwb", 32'(mem_rwb), 0);
    chk("arst_mem_addrb", 32'(mem_addrb), 0);
    chk("arst_mem_dinb", 32'(mem_dinb), 0);
    @(negedge clk);
    chk("arst_edge_ready", 32'(sif.load_ready), 0);
    chk("arst_edge_ge", 32'(ge_start), 0);
    chk("arst_edge_out", 32'(sif.out_valid), 0);
    chk("arst_edge_done", 32'(done), 0);
    cyc();
    sif.load_valid = 1'b0;
    rst_b = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    load_rows(1, 0, 1'b0, 1'b0);
    chk("done_total", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
